// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP (OV5640-style RGB565) byte source.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } dvp_state_t;

    // RGB565 goes out MSB byte ({R,G[5:3]}) first, as OV5640 sensors do.
    localparam bit HIGH_BYTE_FIRST = 1'b1;

    function automatic int line_cyc(input int width, input int hblank);
        return 2 * width + hblank;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_lines(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line timing for the DVP source: state, hcnt, vcnt and look-ahead line strobes.
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int VSYNC_LINES  = 4,
    parameter int VBP_LINES    = 16,
    parameter int VFP_LINES    = 4,
    parameter int HBLANK_CYC   = 256,
    parameter int HW           = cnt_w(line_cyc(IMAGE_WIDTH, HBLANK_CYC)),
    parameter int VW           = cnt_w(max_lines(IMAGE_HEIGHT, VSYNC_LINES, VBP_LINES, VFP_LINES))
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output dvp_state_t    state_nxt,
    output logic [HW-1:0] hcnt_nxt,
    output logic [VW-1:0] vcnt_nxt,
    output logic          line_start,
    output logic          line_end
);

    localparam int LC = line_cyc(IMAGE_WIDTH, HBLANK_CYC);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LC - 1);

    dvp_state_t    state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] vlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = '0;
        vcnt_nxt  = '0;
        case (state)
            ST_VSYNC:  vlast = VW'(VSYNC_LINES - 1);
            ST_VBP:    vlast = VW'(VBP_LINES - 1);
            ST_ACTIVE: vlast = VW'(IMAGE_HEIGHT - 1);
            ST_VFP:    vlast = VW'(VFP_LINES - 1);
            default:   vlast = '0;
        endcase
        // Every state lasts whole lines: transitions only on the last cycle of its last line.
        if (state == ST_IDLE) begin
            if (enable) state_nxt = ST_VSYNC;
        end else if (hcnt != HCNT_LAST) begin
            hcnt_nxt = hcnt + 1'b1;
            vcnt_nxt = vcnt;
        end else if (vcnt != vlast) begin
            vcnt_nxt = vcnt + 1'b1;
        end else begin
            case (state)
                ST_VSYNC:  state_nxt = ST_VBP;
                ST_VBP:    state_nxt = ST_ACTIVE;
                ST_ACTIVE: state_nxt = ST_VFP;
                ST_VFP:    state_nxt = enable ? ST_VSYNC : ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        line_start = (state_nxt != ST_IDLE) && (hcnt_nxt == '0);
        line_end   = (state_nxt != ST_IDLE) && (hcnt_nxt == HCNT_LAST);
    end

endmodule

// File: rtl/dvp_tx.sv
// DVP byte source: serialises RGB565 pixels onto vsync/href/data with fixed frame timing.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int VSYNC_LINES  = 4,
    parameter int VBP_LINES    = 16,
    parameter int VFP_LINES    = 4,
    parameter int HBLANK_CYC   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underflow
);

    localparam int LC = line_cyc(IMAGE_WIDTH, HBLANK_CYC);
    localparam int HW = cnt_w(LC);
    localparam int VW = cnt_w(max_lines(IMAGE_HEIGHT, VSYNC_LINES, VBP_LINES, VFP_LINES));
    localparam logic [HW-1:0] ACT_END  = HW'(2 * IMAGE_WIDTH);
    localparam logic [VW-1:0] VFP_LAST = VW'(VFP_LINES - 1);

    dvp_state_t    state_nxt;
    logic [HW-1:0] hcnt_nxt;
    logic [VW-1:0] vcnt_nxt;
    logic          line_start;
    logic          line_end;
    logic          byte_slot;
    logic [7:0]    first_byte;
    logic [7:0]    second_byte;
    logic [7:0]    lo_byte_p1;

    dvp_timing_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES),
        .HBLANK_CYC  (HBLANK_CYC),
        .HW          (HW),
        .VW          (VW)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .state_nxt (state_nxt),
        .hcnt_nxt  (hcnt_nxt),
        .vcnt_nxt  (vcnt_nxt),
        .line_start(line_start),
        .line_end  (line_end)
    );

    // Outputs are registered from the next timing position, so pix_ready looks one cycle ahead.
    always_comb begin
        byte_slot   = (state_nxt == ST_ACTIVE) && (hcnt_nxt < ACT_END);
        pix_ready   = byte_slot && !hcnt_nxt[0];
        first_byte  = HIGH_BYTE_FIRST ? pix_data[15:8] : pix_data[7:0];
        second_byte = HIGH_BYTE_FIRST ? pix_data[7:0]  : pix_data[15:8];
    end

    // stage p1: second byte of the pixel taken in the ready cycle
    always_ff @(posedge clk) begin
        if (pix_ready) lo_byte_p1 <= pix_valid ? second_byte : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            dvp_vsync   <= (state_nxt == ST_VSYNC);
            dvp_href    <= byte_slot;
            frame_start <= line_start && (state_nxt == ST_VSYNC) && (vcnt_nxt == '0);
            frame_done  <= line_end && (state_nxt == ST_VFP) && (vcnt_nxt == VFP_LAST);
            underflow   <= pix_ready && !pix_valid;
            if (!byte_slot)
                dvp_data <= 8'h00;
            else if (pix_ready)
                dvp_data <= pix_valid ? first_byte : 8'h00;
            else
                dvp_data <= lo_byte_p1;
        end
    end

endmodule
